// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the MEM-stage byte-serial memory initiator.
package mips_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int MEM_BYTE_W = 8;
    localparam int MEM_BEATS  = 4;
    localparam int CNT_W      = $clog2(MEM_BEATS);

endpackage

// File: rtl/mem_byte_initiator.sv
// Splits a 32-bit load/store into four little-endian byte beats on a byte-wide
// memory, assembling load data and freezing the pipeline until the word is done.
module mem_byte_initiator
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int BYTE_W = MEM_BYTE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MEM_R_EN,
    input  logic              MEM_W_EN,
    input  logic [ADDR_W-1:0] Address,
    input  logic [DATA_W-1:0] Write_data,
    output logic              freeze,
    output logic [DATA_W-1:0] Data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [BYTE_W-1:0] mem_wdata,
    output logic              mem_r_en,
    output logic              mem_w_en,
    input  logic [BYTE_W-1:0] mem_rdata
);

    localparam int              BEATS = DATA_W / BYTE_W;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              wr_q, wr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              req;
    int                lane;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        base_d    = base_q;
        wdata_d   = wdata_q;
        wr_d      = wr_q;
        data_d    = data_q;
        freeze    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_r_en  = 1'b0;
        mem_w_en  = 1'b0;
        req       = MEM_R_EN | MEM_W_EN;
        lane      = int'(cnt_q) * BYTE_W;

        case (state_q)
            IDLE: begin
                freeze = req;
                if (req) begin
                    // Low address bits are dropped: every access is a whole aligned word.
                    base_d  = Address & ~ADDR_W'(BEATS - 1);
                    wdata_d = Write_data;
                    wr_d    = MEM_W_EN;
                    cnt_d   = '0;
                    state_d = XFER;
                end
            end
            XFER: begin
                freeze   = 1'b1;
                mem_addr = base_q + ADDR_W'(cnt_q);
                if (wr_q) begin
                    mem_w_en  = 1'b1;
                    mem_wdata = wdata_q[lane +: BYTE_W];
                end else begin
                    mem_r_en               = 1'b1;
                    data_d[lane +: BYTE_W] = mem_rdata;
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Stall must never be asserted while the block is held in reset.
        if (!rst) begin
            freeze = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            base_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            base_q  <= base_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            data_q  <= data_d;
        end
    end

    assign Data = data_q;

endmodule

// File: tb/tb_mem_byte_initiator.sv
// Directed bench for mem_byte_initiator with a small byte memory model.
module tb_mem_byte_initiator;

    logic        clk;
    logic        rst;
    logic        MEM_R_EN;
    logic        MEM_W_EN;
    logic [31:0] Address;
    logic [31:0] Write_data;
    logic        freeze;
    logic [31:0] Data;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_r_en;
    logic        mem_w_en;
    logic [7:0]  mem_rdata;

    logic [7:0]  mem [0:1023];
    int          n_vec;
    int          n_err;
    int          cyc;
    int          c_start;

    mem_byte_initiator #(
        .ADDR_W(32),
        .DATA_W(32),
        .BYTE_W(8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .MEM_R_EN  (MEM_R_EN),
        .MEM_W_EN  (MEM_W_EN),
        .Address   (Address),
        .Write_data(Write_data),
        .freeze    (freeze),
        .Data      (Data),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_r_en  (mem_r_en),
        .mem_w_en  (mem_w_en),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[9:0]];

    always @(posedge clk) begin
        if (mem_w_en) begin
            mem[mem_addr[9:0]] <= mem_wdata;
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic logic [31:0] memword(input int a);
        return {mem[a+3], mem[a+2], mem[a+1], mem[a]};
    endfunction

    // One full access: cycle 0 in IDLE, four beats, DONE; returns in the following IDLE cycle.
    // Inputs are scrambled after beat 0; the optional next request is presented during DONE.
    task automatic run_access(input string nm, input logic rd, input logic wr,
                              input logic [31:0] addr, input logic [31:0] wd,
                              input logic [31:0] exp_base, input logic exp_wr,
                              input logic [31:0] exp_data,
                              input logic nrd, input logic nwr,
                              input logic [31:0] naddr, input logic [31:0] nwd);
        MEM_R_EN   = rd;
        MEM_W_EN   = wr;
        Address    = addr;
        Write_data = wd;
        #1;
        chk({nm, ".c0_freeze"}, freeze, 1);
        chk({nm, ".c0_en"}, {mem_r_en, mem_w_en}, 0);
        tick();
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("%s.b%0d_addr", nm, k), mem_addr, exp_base + k);
            chk($sformatf("%s.b%0d_en", nm, k), {mem_r_en, mem_w_en}, {!exp_wr, exp_wr});
            chk($sformatf("%s.b%0d_freeze", nm, k), freeze, 1);
            if (exp_wr) begin
                chk($sformatf("%s.b%0d_wdata", nm, k), mem_wdata, (wd >> (8 * k)) & 32'hFF);
            end
            if (k == 0) begin
                MEM_R_EN   = 1'b0;
                MEM_W_EN   = 1'b0;
                Address    = 32'h0000_0380;
                Write_data = 32'h5A5A_5A5A;
            end
            tick();
        end
        MEM_R_EN   = nrd;
        MEM_W_EN   = nwr;
        Address    = naddr;
        Write_data = nwd;
        #1;
        chk({nm, ".done_freeze"}, freeze, 0);
        chk({nm, ".done_en"}, {mem_r_en, mem_w_en}, 0);
        chk({nm, ".done_addr"}, mem_addr, 0);
        chk({nm, ".done_data"}, Data, exp_data);
        tick();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        cyc   = 0;
        mem[100] <= 8'hFF;
        mem[101] <= 8'h00;
        mem[102] <= 8'h01;
        mem[103] <= 8'h00;
        mem[400] <= 8'h55;
        mem[401] <= 8'h55;
        mem[402] <= 8'h55;
        mem[403] <= 8'h55;

        rst        = 1'b0;
        MEM_R_EN   = 1'b1;
        MEM_W_EN   = 1'b0;
        Address    = 32'd100;
        Write_data = 32'h0;
        #2;
        chk("rst_freeze", freeze, 0);
        chk("rst_data", Data, 0);
        chk("rst_en", {mem_r_en, mem_w_en}, 0);
        chk("rst_addr", mem_addr, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_hold_freeze", freeze, 0);
        MEM_R_EN = 1'b0;
        rst      = 1'b1;
        tick();
        chk("idle_freeze", freeze, 0);

        run_access("ld100", 1, 0, 32'd100, 32'h0, 32'd100, 0, 32'h000100FF, 0, 0, 0, 0);
        run_access("st200", 0, 1, 32'd200, 32'hDEADBEEF, 32'd200, 1, 32'h000100FF, 0, 0, 0, 0);
        chk("st200_mem", memword(200), 32'hDEADBEEF);
        run_access("ld200", 1, 0, 32'd200, 32'h0, 32'd200, 0, 32'hDEADBEEF, 0, 0, 0, 0);
        run_access("ld103", 1, 0, 32'd103, 32'h0, 32'd100, 0, 32'h000100FF, 0, 0, 0, 0);
        run_access("both300", 1, 1, 32'd300, 32'h11223344, 32'd300, 1, 32'h000100FF, 0, 0, 0, 0);
        chk("both300_mem", memword(300), 32'h11223344);

        c_start = cyc;
        run_access("b2b_ld", 1, 0, 32'd100, 32'h0, 32'd100, 0, 32'h000100FF,
                   0, 1, 32'd200, 32'h0BADF00D);
        run_access("b2b_st", 0, 1, 32'd200, 32'h0BADF00D, 32'd200, 1, 32'h000100FF, 0, 0, 0, 0);
        chk("b2b_cycles", cyc - c_start, 12);
        chk("b2b_mem", memword(200), 32'h0BADF00D);

        MEM_W_EN   = 1'b1;
        Address    = 32'd400;
        Write_data = 32'h87654321;
        tick();
        tick();
        tick();
        chk("rmid_pre_en", mem_w_en, 1);
        chk("rmid_pre_addr", mem_addr, 32'd402);
        #2;
        rst = 1'b0;
        #1;
        chk("rmid_w_en", mem_w_en, 0);
        chk("rmid_freeze", freeze, 0);
        chk("rmid_data", Data, 0);
        chk("rmid_addr", mem_addr, 0);
        @(posedge clk);
        #1;
        chk("rmid_mem400", mem[400], 32'h21);
        chk("rmid_mem401", mem[401], 32'h43);
        chk("rmid_mem402", mem[402], 32'h55);
        chk("rmid_mem403", mem[403], 32'h55);
        MEM_W_EN = 1'b0;
        rst      = 1'b1;
        tick();
        tick();
        chk("post_idle_freeze", freeze, 0);
        chk("post_idle_en", {mem_r_en, mem_w_en}, 0);
        chk("post_idle_data", Data, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
